// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the ALU result path
//   and the memory-load path. One winner per cycle is picked with a
//   valid/ready handshake, and its destination and data are registered into
//   a single writeback stage.
//
//   Arbitration: loads have priority (MEM_PRI) until the ALU has lost
//   STARVE_LIMIT consecutive arbitrations. The FSM then moves to ALU_FORCE,
//   where the ALU wins until it is granted.
//
//   Optional feature: define WB_FWD_EN to add the fwd_ra / fwd_hit / fwd_data
//   forwarding port, which looks up the write that is in flight.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   hold                  stall; no grants while high
//   alu_valid/rd/data     ALU writeback request; alu_ready accepts it
//   mem_valid/rd/data     load writeback request; mem_ready accepts it
//   rf_we/rf_wa/rf_wd     register-file write port (registered)
//   wd_select             registered source of the writeback (0 ALU, 1 MEM)
//   starve_cnt            current ALU starvation count
//   fwd_ra/hit/data       (WB_FWD_EN only) forwarding lookup
module wb_port_arbiter #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              wd_select,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_ra,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [2:0]        starve_cnt
);

  typedef enum logic {MEM_PRI, ALU_FORCE} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] cnt_next;

  // Ready is combinational so that a request can be granted in the cycle it
  // is presented. The two branches are mutually exclusive by construction.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!reset && !hold) begin
      if (state == ALU_FORCE) begin
        alu_ready = alu_valid;
        mem_ready = mem_valid & ~alu_valid;
      end else begin
        mem_ready = mem_valid;
        alu_ready = alu_valid & ~mem_valid;
      end
    end
  end

  // Starvation count: frozen while stalled, and saturates at LIMIT.
  always_comb begin
    cnt_next = starve_cnt;
    if (!hold) begin
      if (alu_valid && !alu_ready)
        cnt_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 3'd1;
      else
        cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MEM_PRI;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      wd_select  <= 1'b0;
    end else begin
      starve_cnt <= cnt_next;
      case (state)
        MEM_PRI:   if (cnt_next == LIMIT) state <= ALU_FORCE;
        ALU_FORCE: if (alu_ready || !alu_valid) state <= MEM_PRI;
        default:   state <= MEM_PRI;
      endcase

      // Register 0 is hardwired zero: the handshake still completes and the
      // source still updates, but no write is issued.
      rf_we <= 1'b0;
      if (alu_ready) begin
        rf_we     <= (alu_rd != '0);
        rf_wa     <= alu_rd;
        rf_wd     <= alu_data;
        wd_select <= 1'b0;
      end else if (mem_ready) begin
        rf_we     <= (mem_rd != '0);
        rf_wa     <= mem_rd;
        rf_wd     <= mem_data;
        wd_select <= 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_hit  = rf_we & (rf_wa == fwd_ra) & (fwd_ra != '0);
  assign fwd_data = rf_wd;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;
  logic        wd_select;
  logic [2:0]  starve_cnt;
`ifdef WB_FWD_EN
  logic [2:0]  fwd_ra;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .wd_select(wd_select),
`ifdef WB_FWD_EN
    .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the ALU is forced once it has lost LIMIT times in a row.
  int          losses;
  logic        e_we, e_sel;
  logic [2:0]  e_wa;
  logic [15:0] e_wd;
  logic [15:0] shadow_rf [8];
  logic        last_alu_win, last_mem_win;

  task automatic model_reset();
    losses = 0; e_we = 0; e_sel = 0; e_wa = '0; e_wd = '0;
  endtask

  // Runs one clock: caller has set inputs; the granted requester drops valid.
  task automatic run_cycle();
    logic aw, mw;
    @(negedge clk);
    aw = !hold && alu_valid && (!mem_valid || losses >= LIMIT);
    mw = !hold && mem_valid && !aw;
    check("alu_ready", alu_ready, aw);
    check("mem_ready", mem_ready, mw);
    check("ready_excl", alu_ready & mem_ready, 0);
    if (!hold) begin
      if (alu_valid && !aw) losses = (losses + 1 > LIMIT) ? LIMIT : losses + 1;
      else losses = 0;
    end
    e_we = 0;
    if (aw) begin
      e_we = (alu_rd != 0); e_wa = alu_rd; e_wd = alu_data; e_sel = 0;
    end else if (mw) begin
      e_we = (mem_rd != 0); e_wa = mem_rd; e_wd = mem_data; e_sel = 1;
    end
    @(posedge clk);
    #1;
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_wa", rf_wa, e_wa);
      check("rf_wd", rf_wd, e_wd);
    end
    check("wd_select", wd_select, e_sel);
    check("starve_cnt", starve_cnt, losses);
`ifdef WB_FWD_EN
    check("fwd_hit", fwd_hit, e_we && (e_wa == fwd_ra) && (fwd_ra != 0));
    if (e_we) check("fwd_data", fwd_data, e_wd);
`endif
    if (rf_we) shadow_rf[rf_wa] = rf_wd;
    last_alu_win = aw;
    last_mem_win = mw;
    if (aw) alu_valid = 0;
    if (mw) mem_valid = 0;
  endtask

  logic [7:0] order;

  initial begin
    reset = 1; hold = 0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
`ifdef WB_FWD_EN
    fwd_ra = '0;
`endif
    for (int i = 0; i < 8; i++) shadow_rf[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", rf_we, 0);
    check("rst_wa", rf_wa, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_sel", wd_select, 0);
    check("rst_cnt", starve_cnt, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Write in flight, then reset mid-write.
    alu_valid = 1; alu_rd = 3'd6; alu_data = 16'hBEEF;
    run_cycle();
    check("pre_rst_we", rf_we, 1);
    alu_valid = 1; mem_valid = 1; alu_rd = 3'd1; mem_rd = 3'd2;
    reset = 1;
    #1;
    check("midrst_we", rf_we, 0);
    check("midrst_wa", rf_wa, 0);
    check("midrst_wd", rf_wd, 0);
    check("midrst_sel", wd_select, 0);
    check("midrst_ardy", alu_ready, 0);
    check("midrst_mrdy", mem_ready, 0);
    @(negedge clk); reset = 0; model_reset();
    alu_valid = 0; mem_valid = 0;
    @(posedge clk); #1;
    alu_valid = 1; alu_rd = 3'd3; alu_data = 16'h1234;
    run_cycle();
    check("post_rst_wa", rf_wa, 3);
    check("post_rst_wd", rf_wd, 16'h1234);
    check("post_rst_sel", wd_select, 0);

    // Contention: both requesters always valid.
    order = '0;
    for (int i = 0; i < 8; i++) begin
      if (!alu_valid) begin alu_valid = 1; alu_rd = 3'(1 + i % 7); alu_data = 16'(16'hA000 + i); end
      if (!mem_valid) begin mem_valid = 1; mem_rd = 3'(7 - i % 7); mem_data = 16'(16'hB000 + i); end
      run_cycle();
      order = {order[6:0], wd_select};
    end
    check("grant_order", order, 8'b1110_1110);

    // hold for 4 cycles with both valid, after a write in flight.
    if (!alu_valid) begin alu_valid = 1; alu_rd = 3'd4; alu_data = 16'h4444; end
    if (!mem_valid) begin mem_valid = 1; mem_rd = 3'd5; mem_data = 16'h5555; end
    run_cycle();
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      if (!alu_valid) begin alu_valid = 1; alu_rd = 3'd4; alu_data = 16'h4000 + 16'(i); end
      if (!mem_valid) begin mem_valid = 1; mem_rd = 3'd5; mem_data = 16'h5000 + 16'(i); end
      run_cycle();
    end
    check("hold_we", rf_we, 0);
    hold = 0;
    run_cycle();
    check("hold_rel_mem", last_mem_win, 1);
    if (alu_valid) run_cycle();

    // R0 write from MEM after an ALU write.
    mem_valid = 0;
    alu_valid = 1; alu_rd = 3'd4; alu_data = 16'h0404;
    run_cycle();
    mem_valid = 1; mem_rd = 3'd0; mem_data = 16'hFFFF;
    run_cycle();
    check("r0_ready", last_mem_win, 1);
    check("r0_we", rf_we, 0);
    check("r0_sel", wd_select, 1);

    // Same rd from both requesters.
    alu_valid = 1; alu_rd = 3'd5; alu_data = 16'h00AA;
    mem_valid = 1; mem_rd = 3'd5; mem_data = 16'h00BB;
    run_cycle();
    check("same_rd_first", rf_wd, 16'h00BB);
    run_cycle();
    check("same_rd_final", shadow_rf[5], 16'h00AA);

`ifdef WB_FWD_EN
    fwd_ra = 3'd2;
    alu_valid = 1; alu_rd = 3'd2; alu_data = 16'h0F0F;
    run_cycle();
    check("fwd_hit_2", fwd_hit, 1);
    check("fwd_data_2", fwd_data, 16'h0F0F);
    fwd_ra = 3'd0; #1;
    check("fwd_hit_0", fwd_hit, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid && $urandom_range(0, 3) != 0) begin
        alu_valid = 1; alu_rd = 3'($urandom); alu_data = 16'($urandom);
      end
      if (!mem_valid && $urandom_range(0, 3) != 0) begin
        mem_valid = 1; mem_rd = 3'($urandom); mem_data = 16'($urandom);
      end
      hold = ($urandom_range(0, 4) == 0);
`ifdef WB_FWD_EN
      fwd_ra = 3'($urandom);
`endif
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
